uncached_store_issue: RTL and testbench
=======================================

# uncached_store_issue

Upstream feeder for the uncached (SRAM-port) side of the AXI write path. Accepts uncached load/store requests from the memory stage via valid/ready, converts each store into a single-beat `mem_write_req` push into the write buffer, and tracks stores still outstanding on AXI. Uncached loads are held until every earlier uncached store has received its B response, which gives strong ordering for MMIO.

## Interface
- `MAX_OUTSTANDING`, default 4: cap on stores issued but not yet acknowledged by B. Must be at most the write buffer's SRAM half (FIFO_DEPTH/2).
- `CNT_W`, default `$clog2(MAX_OUTSTANDING+1)`: width of the outstanding counter.

Ports (name, direction, width, meaning):
- `i_clk` in 1: clock.
- `i_rst` in 1: reset; synchronous, active-high.
- `i_req_valid` in 1: request valid from the memory stage.
- `o_req_ready` out 1: request accepted this cycle.
- `i_req_we` in 1: 1 = store, 0 = load.
- `i_req_addr` in 32: physical address.
- `i_req_size` in 3: AXI size code (0/1/2).
- `i_req_wstrb` in 4: byte enables for the store.
- `i_req_wdata` in 32: store data.
- `o_load_grant` out 1: the pending load may issue on the read path.
- `o_load_addr` out 32: captured load address.
- `o_load_size` out 3: captured load size.
- `i_load_done` in 1: the read path has finished the granted load.
- `o_sram_we` out 1: push pulse into the write buffer.
- `o_sram_req` out `mem_write_req`: addr, len=0, size, wen.
- `o_sram_data` out 32: store data for the push.
- `i_sram_full` in 1: write buffer SRAM half is near-full.
- `i_sram_empty` in 1: write buffer SRAM FIFO is empty.
- `i_sram_start` in 1: AW handshake done for an SRAM entry.
- `i_sram_end` in 1: B response received for an SRAM entry.
- `o_busy` out 1: state ≠ IDLE, or `outstanding` ≠ 0.

## Operation
FSM states: IDLE, DRAIN, GRANT.

IDLE
- `o_req_ready` = `~i_sram_full` & (`outstanding` < MAX_OUTSTANDING).
- Store accept (valid & ready & we):
  - Next cycle `o_sram_we`=1 for exactly one cycle.
  - `o_sram_req` = {addr=`i_req_addr`, len=0, size=`i_req_size`, wen=`i_req_wstrb`}.
  - `o_sram_data` = `i_req_wdata`.
  - `o_sram_req` and `o_sram_data` hold their value until the next accept.
  - State stays IDLE.
- Load accept (valid & ready & ~we): capture addr and size, go to DRAIN.

DRAIN
- `o_req_ready`=0.
- Go to GRANT when `outstanding`==0 & `i_sram_empty` & ~`o_sram_we`.

GRANT
- `o_load_grant`=1, held until `i_load_done`.
- On `i_load_done`, go to IDLE in the same edge. `o_load_grant` drops the following cycle.

Outstanding counter
- +1 on `o_sram_we`, −1 on `i_sram_end`; no change if both occur in the same cycle.
- Never exceeds MAX_OUTSTANDING, because accept is gated on it.
- Underflow (`i_sram_end` with `outstanding`==0) is illegal; the bench asserts on it. RTL holds the counter at 0.
- `i_sram_start` is used only by the assertion that start count ≥ end count. It does not change the counter.

Reset values
- `o_req_ready` is combinational; in reset it evaluates from state IDLE and count 0.
- All other outputs: `o_load_grant`=0, `o_load_addr`=0, `o_load_size`=0, `o_sram_we`=0, `o_sram_req`='0, `o_sram_data`=0, `o_busy`=0.
- State = IDLE, counter = 0.

Reset mid-operation
- Any state returns to IDLE and the pending load is dropped.
- The write buffer is reset by the same `i_rst`, so no reconciliation is needed.

## Timing
- Store accept to `o_sram_we`: 1 cycle. Back-to-back stores push on consecutive cycles.
- `i_sram_full` lags a push by one cycle. The write buffer reports full at (BUFFER_NUM−1), which leaves room for the one in-flight push.
- Load accept to `o_load_grant`, best case with the buffer idle: 2 cycles (DRAIN for 1 cycle, then GRANT).
- Simultaneous `o_sram_we` and `i_sram_end`: net counter change is 0.
- `i_load_done` in the first GRANT cycle is legal.

## Structure
- `mem_write_req` and `word` come from the shared package (def.svh). No new typedefs are added.
- The state enum is local to the module.
- No sub-module. Counter, FSM and the store-capture register stay in one file, roughly 150 lines.

## Test plan
- Single store: addr 0x1FAF_0000, wdata 0xDEAD_BEEF, wstrb 4'hF, size 2 → one `o_sram_we` pulse next cycle with len=0 and those exact fields; `outstanding`=1; after `i_sram_end`, 0.
- 4 back-to-back stores with MAX_OUTSTANDING=4 → 4 consecutive push pulses; 5th request sees `o_req_ready`=0 until the first `i_sram_end`, then accepted the next cycle.
- Store then load with B delayed 10 cycles → `o_load_grant` stays 0 until the cycle after `i_sram_end` and `i_sram_empty`; then 1 with `o_load_addr` equal to the captured address.
- Load with buffer idle → grant 2 cycles after accept; `i_load_done` in the first GRANT cycle → back in IDLE with `o_req_ready`=1 next cycle.
- Push and `i_sram_end` in the same cycle with `outstanding`=2 → `outstanding` stays 2.
- `i_rst` asserted during DRAIN with `outstanding`=3 → next cycle: state IDLE, counter 0, all outputs at reset values.

Source files
------------

// File: rtl/uncached_store_issue_pkg.sv
// Shared types for the uncached write path: data word and the write-buffer push request.
package uncached_store_issue_pkg;

    typedef logic [31:0] word;

    typedef struct packed {
        word        addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [3:0] wen;
    } mem_write_req;

endpackage

// File: rtl/uncached_store_issue.sv
// Feeds uncached stores into the write buffer as single-beat pushes and holds uncached
// loads back until every earlier store has its B response (strong MMIO ordering).
module uncached_store_issue
    import uncached_store_issue_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic         i_req_we,
    input  logic [31:0]  i_req_addr,
    input  logic [2:0]   i_req_size,
    input  logic [3:0]   i_req_wstrb,
    input  logic [31:0]  i_req_wdata,
    output logic         o_load_grant,
    output logic [31:0]  o_load_addr,
    output logic [2:0]   o_load_size,
    input  logic         i_load_done,
    output logic         o_sram_we,
    output mem_write_req o_sram_req,
    output logic [31:0]  o_sram_data,
    input  logic         i_sram_full,
    input  logic         i_sram_empty,
    input  logic         i_sram_start,
    input  logic         i_sram_end,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        GRANT
    } state_e;

    localparam logic [CNT_W:0] MAX_C = (CNT_W + 1)'(MAX_OUTSTANDING);

    state_e       state_q, state_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] aw_pending_q, aw_pending_d;
    logic         sram_we_q, sram_we_d;
    mem_write_req sram_req_q, sram_req_d;
    word          sram_data_q, sram_data_d;
    word          load_addr_q, load_addr_d;
    logic [2:0]   load_size_q, load_size_d;

    logic [CNT_W:0] in_flight;
    logic           req_ready;
    logic           accept;

    // The push still in flight is counted so the cap holds before the counter catches up.
    assign in_flight = {1'b0, outstanding_q} + (CNT_W + 1)'(sram_we_q);
    assign req_ready = (state_q == IDLE) && !i_sram_full && (in_flight < MAX_C);
    assign accept    = i_req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        sram_we_d     = 1'b0;
        sram_req_d    = sram_req_q;
        sram_data_d   = sram_data_q;
        load_addr_d   = load_addr_q;
        load_size_d   = load_size_q;

        case (state_q)
            IDLE: begin
                if (accept && i_req_we) begin
                    sram_we_d       = 1'b1;
                    sram_req_d.addr = i_req_addr;
                    sram_req_d.len  = 8'd0;
                    sram_req_d.size = i_req_size;
                    sram_req_d.wen  = i_req_wstrb;
                    sram_data_d     = i_req_wdata;
                end else if (accept) begin
                    load_addr_d = i_req_addr;
                    load_size_d = i_req_size;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if ((outstanding_q == '0) && i_sram_empty && !sram_we_q) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (i_load_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A push and a B response in the same cycle cancel; an underflowing B is ignored.
    always_comb begin
        outstanding_d = outstanding_q;
        if (sram_we_q && !i_sram_end) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!sram_we_q && i_sram_end && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
        aw_pending_d = aw_pending_q + CNT_W'(i_sram_start) - CNT_W'(i_sram_end);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            aw_pending_q  <= '0;
            sram_we_q     <= 1'b0;
            sram_req_q    <= '0;
            sram_data_q   <= '0;
            load_addr_q   <= '0;
            load_size_q   <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            aw_pending_q  <= aw_pending_d;
            sram_we_q     <= sram_we_d;
            sram_req_q    <= sram_req_d;
            sram_data_q   <= sram_data_d;
            load_addr_q   <= load_addr_d;
            load_size_q   <= load_size_d;
        end
    end

    // A B response must never outrun the AW handshakes that preceded it.
    a_start_before_end: assert property (@(posedge i_clk) disable iff (i_rst)
        i_sram_end |-> ((aw_pending_q != '0) || i_sram_start));

    assign o_req_ready  = req_ready;
    assign o_load_grant = (state_q == GRANT);
    assign o_load_addr  = load_addr_q;
    assign o_load_size  = load_size_q;
    assign o_sram_we    = sram_we_q;
    assign o_sram_req   = sram_req_q;
    assign o_sram_data  = sram_data_q;
    assign o_busy       = (state_q != IDLE) || (outstanding_q != '0);

endmodule

// File: tb/tb_uncached_store_issue.sv
// Directed self-checking bench for uncached_store_issue with hand-computed expectations.
module tb_uncached_store_issue;
    import uncached_store_issue_pkg::*;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [2:0]   req_size;
    logic [3:0]   req_wstrb;
    logic [31:0]  req_wdata;
    logic         load_grant;
    logic [31:0]  load_addr;
    logic [2:0]   load_size;
    logic         load_done;
    logic         sram_we;
    mem_write_req sram_req;
    logic [31:0]  sram_data;
    logic         sram_full;
    logic         sram_empty;
    logic         sram_start;
    logic         sram_end;
    logic         busy;

    int checks;
    int errors;
    int starts_seen;
    int ends_seen;

    uncached_store_issue #(.MAX_OUTSTANDING(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_addr   (req_addr),
        .i_req_size   (req_size),
        .i_req_wstrb  (req_wstrb),
        .i_req_wdata  (req_wdata),
        .o_load_grant (load_grant),
        .o_load_addr  (load_addr),
        .o_load_size  (load_size),
        .i_load_done  (load_done),
        .o_sram_we    (sram_we),
        .o_sram_req   (sram_req),
        .o_sram_data  (sram_data),
        .i_sram_full  (sram_full),
        .i_sram_empty (sram_empty),
        .i_sram_start (sram_start),
        .i_sram_end   (sram_end),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AW start count must never fall behind B end count.
    always @(posedge clk) begin
        if (rst) begin
            starts_seen <= 0;
            ends_seen   <= 0;
        end else begin
            if (sram_end) begin
                checks = checks + 1;
                if (ends_seen + 1 > starts_seen + int'(sram_start)) begin
                    errors = errors + 1;
                    $display("[TB] FAIL start_ge_end: ends %0d starts %0d", ends_seen + 1, starts_seen + int'(sram_start));
                end
            end
            starts_seen <= starts_seen + int'(sram_start);
            ends_seen   <= ends_seen + int'(sram_end);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks = checks + 8;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b want 1", req_ready); end
        if (load_grant !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant: got %0b want 0", load_grant); end
        if (load_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_load_addr: got %h want 0", load_addr); end
        if (load_size !== 3'd0) begin errors++; $display("[TB] FAIL reset_load_size: got %0d want 0", load_size); end
        if (sram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_sram_we: got %0b want 0", sram_we); end
        if (sram_req !== '0) begin errors++; $display("[TB] FAIL reset_sram_req: got %h want 0", sram_req); end
        if (sram_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_sram_data: got %h want 0", sram_data); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_store();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1FAF_0000;
        req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF; req_size = 3'd2;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %0b want 1", req_ready); end
        step();
        req_valid = 1'b0; sram_empty = 1'b0;
        checks = checks + 6;
        if (sram_we !== 1'b1) begin errors++; $display("[TB] FAIL single_push: got %0b want 1", sram_we); end
        if (sram_req.addr !== 32'h1FAF_0000) begin errors++; $display("[TB] FAIL single_addr: got %h want 1faf0000", sram_req.addr); end
        if (sram_req.len !== 8'd0) begin errors++; $display("[TB] FAIL single_len: got %0d want 0", sram_req.len); end
        if (sram_req.size !== 3'd2) begin errors++; $display("[TB] FAIL single_size: got %0d want 2", sram_req.size); end
        if (sram_req.wen !== 4'hF) begin errors++; $display("[TB] FAIL single_wen: got %h want f", sram_req.wen); end
        if (sram_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL single_data: got %h want deadbeef", sram_data); end
        step();
        checks = checks + 4;
        if (sram_we !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse_end: got %0b want 0", sram_we); end
        if (dut.outstanding_q !== 3'd1) begin errors++; $display("[TB] FAIL single_outstanding: got %0d want 1", dut.outstanding_q); end
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %0b want 1", busy); end
        if (sram_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL single_data_hold: got %h want deadbeef", sram_data); end
        sram_start = 1'b1;
        step();
        sram_start = 1'b0; sram_end = 1'b1; sram_empty = 1'b1;
        step();
        sram_end = 1'b0;
        checks = checks + 2;
        if (dut.outstanding_q !== 3'd0) begin errors++; $display("[TB] FAIL single_after_b: got %0d want 0", dut.outstanding_q); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'd2; req_wstrb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_addr  = 32'h1000_0000 + 32'(i * 4);
            req_wdata = 32'hA000_0000 + 32'(i);
            checks++;
            if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_%0d: got %0b want 1", i, req_ready); end
            step();
            sram_empty = 1'b0;
            checks = checks + 2;
            if (sram_we !== 1'b1) begin errors++; $display("[TB] FAIL b2b_push_%0d: got %0b want 1", i, sram_we); end
            if (sram_data !== 32'hA000_0000 + 32'(i)) begin errors++; $display("[TB] FAIL b2b_data_%0d: got %h want %h", i, sram_data, 32'hA000_0000 + 32'(i)); end
        end
        req_addr = 32'h1000_0010; req_wdata = 32'hA000_0004;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_fifth_blocked: got %0b want 0", req_ready); end
        sram_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall_%0d: got %0b want 0", i, req_ready); end
        end
        checks++;
        if (dut.outstanding_q !== 3'd4) begin errors++; $display("[TB] FAIL b2b_full_count: got %0d want 4", dut.outstanding_q); end
        sram_start = 1'b0; sram_end = 1'b1;
        step();
        sram_end = 1'b0;
        checks = checks + 2;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_after_b: got %0b want 1", req_ready); end
        if (dut.outstanding_q !== 3'd3) begin errors++; $display("[TB] FAIL b2b_count_after_b: got %0d want 3", dut.outstanding_q); end
        step();
        req_valid = 1'b0;
        checks = checks + 2;
        if (sram_we !== 1'b1) begin errors++; $display("[TB] FAIL b2b_fifth_push: got %0b want 1", sram_we); end
        if (sram_data !== 32'hA000_0004) begin errors++; $display("[TB] FAIL b2b_fifth_data: got %h want a0000004", sram_data); end
        step();
        for (int i = 0; i < 4; i++) begin
            sram_start = (i == 0);
            sram_end   = 1'b1;
            step();
        end
        sram_start = 1'b0; sram_end = 1'b0; sram_empty = 1'b1;
        checks++;
        if (dut.outstanding_q !== 3'd0) begin errors++; $display("[TB] FAIL b2b_drained: got %0d want 0", dut.outstanding_q); end
    endtask

    task automatic test_store_then_load();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2000_0000;
        req_wdata = 32'h1234_5678; req_size = 3'd2; req_wstrb = 4'hF;
        step();
        sram_empty = 1'b0;
        req_we = 1'b0; req_addr = 32'h1FAF_0010; req_size = 3'd2;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL stl_load_ready: got %0b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        checks = checks + 2;
        if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL stl_drain_ready: got %0b want 0", req_ready); end
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stl_busy: got %0b want 1", busy); end
        sram_start = 1'b1;
        step();
        sram_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (load_grant !== 1'b0) begin errors++; $display("[TB] FAIL stl_wait_%0d: got %0b want 0", i, load_grant); end
            step();
        end
        sram_end = 1'b1; sram_empty = 1'b1;
        step();
        sram_end = 1'b0;
        checks++;
        if (load_grant !== 1'b0) begin errors++; $display("[TB] FAIL stl_b_edge: got %0b want 0", load_grant); end
        step();
        checks = checks + 3;
        if (load_grant !== 1'b1) begin errors++; $display("[TB] FAIL stl_grant: got %0b want 1", load_grant); end
        if (load_addr !== 32'h1FAF_0010) begin errors++; $display("[TB] FAIL stl_addr: got %h want 1faf0010", load_addr); end
        if (load_size !== 3'd2) begin errors++; $display("[TB] FAIL stl_size: got %0d want 2", load_size); end
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        checks = checks + 2;
        if (load_grant !== 1'b0) begin errors++; $display("[TB] FAIL stl_grant_drop: got %0b want 0", load_grant); end
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL stl_idle_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_idle_load();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3000_0044; req_size = 3'd1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_load_ready: got %0b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        checks = checks + 2;
        if (load_grant !== 1'b0) begin errors++; $display("[TB] FAIL idle_drain_grant: got %0b want 0", load_grant); end
        if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_drain_ready: got %0b want 0", req_ready); end
        step();
        checks = checks + 3;
        if (load_grant !== 1'b1) begin errors++; $display("[TB] FAIL idle_grant: got %0b want 1", load_grant); end
        if (load_addr !== 32'h3000_0044) begin errors++; $display("[TB] FAIL idle_addr: got %h want 30000044", load_addr); end
        if (load_size !== 3'd1) begin errors++; $display("[TB] FAIL idle_size: got %0d want 1", load_size); end
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        checks = checks + 3;
        if (load_grant !== 1'b0) begin errors++; $display("[TB] FAIL idle_grant_drop: got %0b want 0", load_grant); end
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_back_ready: got %0b want 1", req_ready); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_back_busy: got %0b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'd2; req_wstrb = 4'h3;
        req_addr = 32'h4000_0000; req_wdata = 32'h0000_0001;
        step();
        sram_empty = 1'b0;
        req_addr = 32'h4000_0004; req_wdata = 32'h0000_0002;
        step();
        req_valid = 1'b0;
        step();
        checks++;
        if (dut.outstanding_q !== 3'd2) begin errors++; $display("[TB] FAIL sim_pre_count: got %0d want 2", dut.outstanding_q); end
        req_valid = 1'b1; req_addr = 32'h4000_0008; req_wdata = 32'h0000_0003;
        sram_start = 1'b1;
        step();
        req_valid = 1'b0; sram_end = 1'b1;
        checks++;
        if (sram_we !== 1'b1) begin errors++; $display("[TB] FAIL sim_push: got %0b want 1", sram_we); end
        step();
        checks++;
        if (dut.outstanding_q !== 3'd2) begin errors++; $display("[TB] FAIL sim_net_zero: got %0d want 2", dut.outstanding_q); end
        sram_start = 1'b1; sram_end = 1'b1;
        step();
        sram_start = 1'b0;
        step();
        sram_end = 1'b0; sram_empty = 1'b1;
        checks++;
        if (dut.outstanding_q !== 3'd0) begin errors++; $display("[TB] FAIL sim_drained: got %0d want 0", dut.outstanding_q); end
    endtask

    task automatic test_reset_in_drain();
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'd2; req_wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            req_addr  = 32'h5000_0000 + 32'(i * 4);
            req_wdata = 32'hB000_0000 + 32'(i);
            step();
            sram_empty = 1'b0;
        end
        req_we = 1'b0; req_addr = 32'h5000_0100; req_size = 3'd2;
        step();
        req_valid = 1'b0;
        checks = checks + 2;
        if (dut.outstanding_q !== 3'd3) begin errors++; $display("[TB] FAIL rd_count: got %0d want 3", dut.outstanding_q); end
        if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rd_drain_ready: got %0b want 0", req_ready); end
        rst = 1'b1;
        step();
        checks = checks + 9;
        if (dut.outstanding_q !== 3'd0) begin errors++; $display("[TB] FAIL rd_count_reset: got %0d want 0", dut.outstanding_q); end
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rd_ready: got %0b want 1", req_ready); end
        if (load_grant !== 1'b0) begin errors++; $display("[TB] FAIL rd_grant: got %0b want 0", load_grant); end
        if (load_addr !== 32'd0) begin errors++; $display("[TB] FAIL rd_load_addr: got %h want 0", load_addr); end
        if (load_size !== 3'd0) begin errors++; $display("[TB] FAIL rd_load_size: got %0d want 0", load_size); end
        if (sram_we !== 1'b0) begin errors++; $display("[TB] FAIL rd_sram_we: got %0b want 0", sram_we); end
        if (sram_req !== '0) begin errors++; $display("[TB] FAIL rd_sram_req: got %h want 0", sram_req); end
        if (sram_data !== 32'd0) begin errors++; $display("[TB] FAIL rd_sram_data: got %h want 0", sram_data); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rd_busy: got %0b want 0", busy); end
        rst = 1'b0; sram_empty = 1'b1;
        step();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_wstrb = '0; req_wdata = '0; load_done = 1'b0; sram_full = 1'b0;
        sram_empty = 1'b1; sram_start = 1'b0; sram_end = 1'b0;
        test_reset();
        test_single_store();
        test_back_to_back();
        test_store_then_load();
        test_idle_load();
        test_simultaneous();
        test_reset_in_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
